// File: rtl/yutorina_ctrl_stage_pkg.sv
// rtl/yutorina_ctrl_stage_pkg.sv - shared widths, codes and helpers for the control stage
//
// Purpose: bus widths, exception codes, control-op codes, SPR addresses,
//          STATUS bit positions and the control FSM state encoding.
// Ports:   none (package).
package yutorina_ctrl_stage_pkg;

  localparam int WORD_DATA_W = 32;
  localparam int WORD_ADDR_W = 30;
  localparam int GPR_ADDR_W  = 5;
  localparam int SPR_ADDR_W  = 5;
  localparam int EXP_W       = 3;
  localparam int CTRL_OP_W   = 2;

  // Exception codes
  localparam logic [EXP_W-1:0] EXP_NONE             = 3'd0;
  localparam logic [EXP_W-1:0] EXP_IRQ              = 3'd1;
  localparam logic [EXP_W-1:0] EXP_ILLEGAL          = 3'd2;
  localparam logic [EXP_W-1:0] EXP_TRAP             = 3'd3;
  localparam logic [EXP_W-1:0] EXP_LOAD_MISS_ALIGN  = 3'd4;
  localparam logic [EXP_W-1:0] EXP_STORE_MISS_ALIGN = 3'd5;
  localparam logic [EXP_W-1:0] EXP_OVERFLOW         = 3'd6;

  // Control ops carried down from decode
  localparam logic [CTRL_OP_W-1:0] CTRL_NONE = 2'd0;
  localparam logic [CTRL_OP_W-1:0] CTRL_SSR  = 2'd1;
  localparam logic [CTRL_OP_W-1:0] CTRL_ERET = 2'd2;
  localparam logic [CTRL_OP_W-1:0] CTRL_HALT = 2'd3;

  // Special-purpose register map
  localparam logic [SPR_ADDR_W-1:0] SPR_STATUS = 5'd0;
  localparam logic [SPR_ADDR_W-1:0] SPR_EPC    = 5'd1;
  localparam logic [SPR_ADDR_W-1:0] SPR_CAUSE  = 5'd2;
  localparam logic [SPR_ADDR_W-1:0] SPR_EVEC   = 5'd3;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_PIE = 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_t;

  // Value a register at 'addr' would hold after being written with 'data':
  // only the implemented bits survive, unmapped addresses read as zero.
  function automatic logic [WORD_DATA_W-1:0] spr_mask(
    input logic [SPR_ADDR_W-1:0]  addr,
    input logic [WORD_DATA_W-1:0] data
  );
    logic [WORD_DATA_W-1:0] v;
    v = '0;
    case (addr)
      SPR_STATUS: v = {30'b0, data[STATUS_PIE], data[STATUS_IE]};
      SPR_EPC:    v = {2'b0, data[WORD_ADDR_W-1:0]};
      SPR_CAUSE:  v = {29'b0, data[EXP_W-1:0]};
      SPR_EVEC:   v = {2'b0, data[WORD_ADDR_W-1:0]};
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/yutorina_spr_file.sv
// rtl/yutorina_spr_file.sv - STATUS/EPC/CAUSE/EVEC storage with write priority and read bypass
//
// Purpose: holds the four special-purpose registers. Software writes from the
//          SSR path are applied first; exception/IRQ entry, EPC capture and
//          ERET then override only the fields they touch.
// Ports:
//   clk        in   clock
//   i_rst      in   synchronous active-high reset
//   i_wr_req   in   SSR write present this cycle (drives the read bypass)
//   i_wr_en    in   SSR write commits at this edge
//   i_w_addr   in   SSR target address
//   i_w_data   in   SSR write data
//   i_take     in   exception/IRQ entry: CAUSE<-i_cause, pie<-ie, ie<-0
//   i_cause    in   cause code for i_take
//   i_epc_we   in   EPC capture enable
//   i_epc_d    in   EPC capture value
//   i_eret     in   return from exception: ie<-pie
//   i_r_addr   in   read address
//   o_r_data   out  read data (combinational, bypassed)
//   o_ie       out  STATUS.ie
//   o_epc      out  EPC
//   o_evec     out  EVEC
module yutorina_spr_file
  import yutorina_ctrl_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_wr_req,
  input  logic                   i_wr_en,
  input  logic [SPR_ADDR_W-1:0]  i_w_addr,
  input  logic [WORD_DATA_W-1:0] i_w_data,
  input  logic                   i_take,
  input  logic [EXP_W-1:0]       i_cause,
  input  logic                   i_epc_we,
  input  logic [WORD_ADDR_W-1:0] i_epc_d,
  input  logic                   i_eret,
  input  logic [SPR_ADDR_W-1:0]  i_r_addr,
  output logic [WORD_DATA_W-1:0] o_r_data,
  output logic                   o_ie,
  output logic [WORD_ADDR_W-1:0] o_epc,
  output logic [WORD_ADDR_W-1:0] o_evec
);

  logic                   r_ie;
  logic                   r_pie;
  logic [WORD_ADDR_W-1:0] r_epc;
  logic [EXP_W-1:0]       r_cause;
  logic [WORD_ADDR_W-1:0] r_evec;

  // Later assignments in this block win, so the SSR write is applied first and
  // the hardware-event updates overwrite just the fields they own.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_ie    <= 1'b0;
      r_pie   <= 1'b0;
      r_epc   <= '0;
      r_cause <= '0;
      r_evec  <= '0;
    end else begin
      if (i_wr_en) begin
        case (i_w_addr)
          SPR_STATUS: begin
            r_ie  <= i_w_data[STATUS_IE];
            r_pie <= i_w_data[STATUS_PIE];
          end
          SPR_EPC:   r_epc   <= i_w_data[WORD_ADDR_W-1:0];
          SPR_CAUSE: r_cause <= i_w_data[EXP_W-1:0];
          SPR_EVEC:  r_evec  <= i_w_data[WORD_ADDR_W-1:0];
          default:   ;
        endcase
      end
      if (i_epc_we) begin
        r_epc <= i_epc_d;
      end
      if (i_take) begin
        r_cause <= i_cause;
        r_pie   <= r_ie;
        r_ie    <= 1'b0;
      end
      if (i_eret) begin
        r_ie <= r_pie;
      end
    end
  end

  always_comb begin
    o_r_data = '0;
    if (i_wr_req && (i_r_addr == i_w_addr)) begin
      o_r_data = spr_mask(i_w_addr, i_w_data);
    end else begin
      case (i_r_addr)
        SPR_STATUS: o_r_data = {30'b0, r_pie, r_ie};
        SPR_EPC:    o_r_data = {2'b0, r_epc};
        SPR_CAUSE:  o_r_data = {29'b0, r_cause};
        SPR_EVEC:   o_r_data = {2'b0, r_evec};
        default:    o_r_data = '0;
      endcase
    end
  end

  assign o_ie   = r_ie;
  assign o_epc  = r_epc;
  assign o_evec = r_evec;

endmodule

// File: rtl/yutorina_ctrl_stage.sv
// rtl/yutorina_ctrl_stage.sv - retire stage: GPR write-back, SPRs, exceptions, IRQ, ERET, HALT
//
// Purpose: retires instructions from MEM, decides exception/IRQ/ERET/HALT
//          redirects, owns the RUN/DRAIN/HALT control FSM and the SPR file.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   stall                             global stall (freezes state, masks side effects)
//   mem_en_                           instruction valid (active low)
//   mem_pc                            successor PC, or faulting PC on exception
//   mem_w_addr, mem_gpr_we_, mem_out  GPR write request
//   mem_exp_code, mem_ctrl_op         exception code, control op
//   spr_w_addr, spr_we_, spr_w_data   SPR write from the owning SSR
//   irq                               level-sensitive interrupt
//   spr_r_addr, spr_r_data            decode-side SPR read
//   gpr_we_, gpr_w_addr, gpr_w_data   GPR write port
//   flush, new_pc                     pipeline kill and redirect target
//   halted                            core is halted
module yutorina_ctrl_stage
  import yutorina_ctrl_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   mem_en_,
  input  logic [WORD_ADDR_W-1:0] mem_pc,
  input  logic [GPR_ADDR_W-1:0]  mem_w_addr,
  input  logic                   mem_gpr_we_,
  input  logic [WORD_DATA_W-1:0] mem_out,
  input  logic [EXP_W-1:0]       mem_exp_code,
  input  logic [CTRL_OP_W-1:0]   mem_ctrl_op,
  input  logic [SPR_ADDR_W-1:0]  spr_w_addr,
  input  logic                   spr_we_,
  input  logic [WORD_DATA_W-1:0] spr_w_data,
  input  logic                   irq,
  input  logic [SPR_ADDR_W-1:0]  spr_r_addr,
  output logic [WORD_DATA_W-1:0] spr_r_data,
  output logic                   gpr_we_,
  output logic [GPR_ADDR_W-1:0]  gpr_w_addr,
  output logic [WORD_DATA_W-1:0] gpr_w_data,
  output logic                   flush,
  output logic [WORD_ADDR_W-1:0] new_pc,
  output logic                   halted
);

  ctrl_state_t r_state;
  logic        r_halted;

  logic                   w_ie;
  logic [WORD_ADDR_W-1:0] w_epc;
  logic [WORD_ADDR_W-1:0] w_evec;

  logic             w_live;
  logic             w_run_valid;
  logic             w_exc;
  logic             w_irq_run;
  logic             w_eret;
  logic             w_halt;
  logic             w_halt_irq;
  logic             w_take;
  logic             w_epc_we;
  logic             w_spr_req;
  logic [EXP_W-1:0] w_cause;

  // Event decode in priority order. Every event is qualified by !stall so a
  // stalled instruction has no visible effect and is simply re-evaluated.
  always_comb begin
    w_live      = !rst && !stall;
    w_run_valid = w_live && (r_state == ST_RUN) && !mem_en_;
    w_exc       = w_run_valid && (mem_exp_code != EXP_NONE);
    w_irq_run   = w_run_valid && !w_exc && irq && w_ie;
    w_eret      = w_run_valid && !w_exc && !w_irq_run && (mem_ctrl_op == CTRL_ERET);
    w_halt      = w_run_valid && !w_exc && !w_irq_run && (mem_ctrl_op == CTRL_HALT);
    w_halt_irq  = w_live && (r_state == ST_HALT) && irq && w_ie;
    w_take      = w_exc || w_irq_run || w_halt_irq;
    // Waking from HALT keeps the resume PC captured when HALT retired.
    w_epc_we    = w_exc || w_irq_run || w_halt;
    w_cause     = w_exc ? mem_exp_code : EXP_IRQ;
    // SSR write (and its read bypass) exists in RUN whether or not stalled;
    // the commit itself is additionally gated by stall.
    w_spr_req   = !rst && (r_state == ST_RUN) && !spr_we_;
  end

  always_comb begin
    new_pc = '0;
    if (w_take) begin
      new_pc = w_evec;
    end else if (w_eret) begin
      new_pc = w_epc;
    end else if (w_halt) begin
      new_pc = mem_pc;
    end
  end

  // A faulting instruction never writes its GPR; an IRQ-interrupted one does.
  assign gpr_we_    = !(w_run_valid && !w_exc && !mem_gpr_we_);
  assign gpr_w_addr = mem_w_addr;
  assign gpr_w_data = mem_out;
  assign flush      = w_take || w_eret || w_halt;
  assign halted     = r_halted && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        ST_RUN: begin
          if (w_exc || w_irq_run || w_eret) begin
            r_state <= ST_DRAIN;
          end else if (w_halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end
        end
        // MEM still shows the flushed instruction here, so one cycle is skipped.
        ST_DRAIN: begin
          r_state <= ST_RUN;
        end
        ST_HALT: begin
          if (w_halt_irq) begin
            r_state  <= ST_DRAIN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  yutorina_spr_file u_spr_file (
    .clk      (clk),
    .i_rst    (rst),
    .i_wr_req (w_spr_req),
    .i_wr_en  (w_spr_req && !stall),
    .i_w_addr (spr_w_addr),
    .i_w_data (spr_w_data),
    .i_take   (w_take),
    .i_cause  (w_cause),
    .i_epc_we (w_epc_we),
    .i_epc_d  (mem_pc),
    .i_eret   (w_eret),
    .i_r_addr (spr_r_addr),
    .o_r_data (spr_r_data),
    .o_ie     (w_ie),
    .o_epc    (w_epc),
    .o_evec   (w_evec)
  );

endmodule

// File: tb/tb_yutorina_ctrl_stage.sv
// tb/tb_yutorina_ctrl_stage.sv - self-checking bench for yutorina_ctrl_stage
module tb_yutorina_ctrl_stage;
  import yutorina_ctrl_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, mem_en_, mem_gpr_we_, spr_we_, irq;
  logic [29:0] mem_pc;
  logic [4:0]  mem_w_addr, spr_w_addr, spr_r_addr;
  logic [31:0] mem_out, spr_w_data;
  logic [2:0]  mem_exp_code;
  logic [1:0]  mem_ctrl_op;
  logic [31:0] spr_r_data, gpr_w_data;
  logic        gpr_we_, flush, halted;
  logic [4:0]  gpr_w_addr;
  logic [29:0] new_pc;

  int n_chk  = 0;
  int n_fail = 0;

  yutorina_ctrl_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .mem_en_(mem_en_), .mem_pc(mem_pc),
    .mem_w_addr(mem_w_addr), .mem_gpr_we_(mem_gpr_we_), .mem_out(mem_out),
    .mem_exp_code(mem_exp_code), .mem_ctrl_op(mem_ctrl_op),
    .spr_w_addr(spr_w_addr), .spr_we_(spr_we_), .spr_w_data(spr_w_data),
    .irq(irq), .spr_r_addr(spr_r_addr), .spr_r_data(spr_r_data),
    .gpr_we_(gpr_we_), .gpr_w_addr(gpr_w_addr), .gpr_w_data(gpr_w_data),
    .flush(flush), .new_pc(new_pc), .halted(halted)
  );

  typedef struct {
    logic rst, stall, en_, gwe_, swe_, irq;
    logic [29:0] pc;
    logic [4:0]  waddr, saddr, raddr;
    logic [31:0] out, sdata;
    logic [2:0]  exp;
    logic [1:0]  op;
    logic        e_we_, e_fl, e_halt, chk_rd, chk_gpr;
    logic [29:0] e_npc;
    logic [31:0] e_rd, e_wdata;
    logic [4:0]  e_waddr;
  } vec_t;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0d: got 0x%0h, want 0x%0h", nm, id, act, expv);
    end
  endtask

  function automatic vec_t idle(input logic [4:0] raddr);
    vec_t v;
    v.rst = 0; v.stall = 0; v.en_ = 1; v.gwe_ = 1; v.swe_ = 1; v.irq = 0;
    v.pc = '0; v.waddr = '0; v.saddr = '0; v.raddr = raddr;
    v.out = '0; v.sdata = '0; v.exp = EXP_NONE; v.op = CTRL_NONE;
    v.e_we_ = 1; v.e_fl = 0; v.e_halt = 0; v.chk_rd = 0; v.chk_gpr = 0;
    v.e_npc = '0; v.e_rd = '0; v.e_wdata = '0; v.e_waddr = '0;
    return v;
  endfunction

  function automatic vec_t rd(input logic [4:0] a, input logic [31:0] e);
    vec_t v;
    v = idle(a); v.chk_rd = 1; v.e_rd = e;
    return v;
  endfunction

  function automatic vec_t ssr(input logic [4:0] a, input logic [31:0] d);
    vec_t v;
    v = rd(a, d); v.en_ = 0; v.op = CTRL_SSR; v.saddr = a; v.swe_ = 0; v.sdata = d;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; mem_en_ = v.en_; mem_pc = v.pc;
    mem_w_addr = v.waddr; mem_gpr_we_ = v.gwe_; mem_out = v.out;
    mem_exp_code = v.exp; mem_ctrl_op = v.op; spr_w_addr = v.saddr;
    spr_we_ = v.swe_; spr_w_data = v.sdata; irq = v.irq; spr_r_addr = v.raddr;
  endtask

  task automatic apply(input vec_t v, input int id);
    drive(v);
    @(negedge clk);
    chk(id, "gpr_we_", 32'(gpr_we_), 32'(v.e_we_));
    chk(id, "flush", 32'(flush), 32'(v.e_fl));
    chk(id, "new_pc", 32'(new_pc), 32'(v.e_npc));
    chk(id, "halted", 32'(halted), 32'(v.e_halt));
    if (v.chk_rd) chk(id, "spr_r_data", spr_r_data, v.e_rd);
    if (v.chk_gpr) begin
      chk(id, "gpr_w_addr", 32'(gpr_w_addr), 32'(v.e_waddr));
      chk(id, "gpr_w_data", gpr_w_data, v.e_wdata);
    end
    @(posedge clk); #1;
  endtask

  // Reference model: architectural state plus mode (0 run, 1 drain, 2 halt).
  logic        m_ie, m_pie, m_known;
  logic [29:0] m_epc, m_evec;
  logic [2:0]  m_cause;
  int          m_mode;
  logic        nx_ie, nx_pie;
  logic [29:0] nx_epc, nx_evec;
  logic [2:0]  nx_cause;
  int          nx_mode;
  logic        ex_we_, ex_fl, ex_halt;
  logic [29:0] ex_npc;
  logic [31:0] ex_rd;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd0:    return {30'b0, m_pie, m_ie};
      5'd1:    return {2'b0, m_epc};
      5'd2:    return {29'b0, m_cause};
      5'd3:    return {2'b0, m_evec};
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [31:0] w_view(input logic [4:0] a, input logic [31:0] d);
    case (a)
      5'd0:    return {30'b0, d[1:0]};
      5'd1:    return {2'b0, d[29:0]};
      5'd2:    return {29'b0, d[2:0]};
      5'd3:    return {2'b0, d[29:0]};
      default: return 32'b0;
    endcase
  endfunction

  task automatic enter_trap(input logic [2:0] code, input logic set_epc);
    ex_fl = 1; ex_npc = m_evec;
    if (set_epc) nx_epc = mem_pc;
    nx_cause = code; nx_pie = m_ie; nx_ie = 0; nx_mode = 1;
  endtask

  task automatic model_eval();
    logic wreq;
    nx_ie = m_ie; nx_pie = m_pie; nx_epc = m_epc; nx_evec = m_evec;
    nx_cause = m_cause; nx_mode = m_mode;
    ex_we_ = 1; ex_fl = 0; ex_npc = '0;
    ex_halt = (m_mode == 2) && !rst;
    wreq = !rst && (m_mode == 0) && !spr_we_;
    ex_rd = (wreq && spr_r_addr == spr_w_addr) ? w_view(spr_w_addr, spr_w_data) : m_read(spr_r_addr);
    if (rst) begin
      nx_ie = 0; nx_pie = 0; nx_epc = '0; nx_evec = '0; nx_cause = '0; nx_mode = 0;
    end else if (!stall) begin
      if (m_mode == 1) begin
        nx_mode = 0;
      end else if (m_mode == 2) begin
        if (irq && m_ie) enter_trap(3'd1, 1'b0);
      end else begin
        if (wreq) begin
          case (spr_w_addr)
            5'd0: begin nx_ie = spr_w_data[0]; nx_pie = spr_w_data[1]; end
            5'd1: nx_epc = spr_w_data[29:0];
            5'd2: nx_cause = spr_w_data[2:0];
            5'd3: nx_evec = spr_w_data[29:0];
            default: ;
          endcase
        end
        if (!mem_en_) begin
          if (mem_exp_code != 3'd0) begin
            enter_trap(mem_exp_code, 1'b1);
          end else begin
            ex_we_ = mem_gpr_we_;
            if (irq && m_ie) begin
              enter_trap(3'd1, 1'b1);
            end else if (mem_ctrl_op == 2'd2) begin
              ex_fl = 1; ex_npc = m_epc; nx_ie = m_pie; nx_mode = 1;
            end else if (mem_ctrl_op == 2'd3) begin
              ex_fl = 1; ex_npc = mem_pc; nx_epc = mem_pc; nx_mode = 2;
            end
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    if (rst) m_known = 1;
    m_ie = nx_ie; m_pie = nx_pie; m_epc = nx_epc; m_evec = nx_evec;
    m_cause = nx_cause; m_mode = nx_mode;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    vec_t t;
    drive(idle(0));
    rst = 1;
    @(posedge clk); #1;

    // Directed table
    v = rd(SPR_EVEC, 0); v.rst = 1; tbl.push_back(v);
    v = idle(0); v.en_ = 0; v.pc = 30'h11; v.waddr = 3; v.gwe_ = 0; v.out = 32'h1234;
    v.e_we_ = 0; v.chk_gpr = 1; v.e_waddr = 3; v.e_wdata = 32'h1234; tbl.push_back(v);
    tbl.push_back(ssr(SPR_EVEC, 32'h100));
    v = rd(SPR_EVEC, 32'h100); v.en_ = 0; v.pc = 30'h40; v.exp = EXP_LOAD_MISS_ALIGN;
    v.gwe_ = 0; v.waddr = 7; v.out = 5; v.e_fl = 1; v.e_npc = 30'h100; tbl.push_back(v);
    v = rd(SPR_EPC, 32'h40); v.en_ = 0; v.gwe_ = 0; v.waddr = 4; v.out = 9;
    v.exp = EXP_LOAD_MISS_ALIGN; v.op = CTRL_HALT; tbl.push_back(v);
    tbl.push_back(rd(SPR_CAUSE, 4));
    tbl.push_back(rd(SPR_STATUS, 0));
    tbl.push_back(ssr(SPR_STATUS, 1));
    v = rd(SPR_STATUS, 1); v.en_ = 0; v.pc = 30'h21; v.gwe_ = 0; v.waddr = 5; v.out = 32'hAA;
    v.irq = 1; v.e_we_ = 0; v.chk_gpr = 1; v.e_waddr = 5; v.e_wdata = 32'hAA;
    v.e_fl = 1; v.e_npc = 30'h100; tbl.push_back(v);
    v = rd(SPR_EPC, 32'h21); v.irq = 1; v.en_ = 0; v.gwe_ = 0; tbl.push_back(v);
    tbl.push_back(rd(SPR_CAUSE, 1));
    tbl.push_back(rd(SPR_STATUS, 2));
    v = rd(SPR_EPC, 32'h21); v.en_ = 0; v.op = CTRL_ERET; v.e_fl = 1; v.e_npc = 30'h21; tbl.push_back(v);
    tbl.push_back(rd(SPR_STATUS, 3));
    v = idle(0); v.en_ = 0; v.op = CTRL_HALT; v.pc = 30'h50; v.e_fl = 1; v.e_npc = 30'h50; tbl.push_back(v);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // HALT with ie=1: idle with junk inputs, then an irq pulse wakes it
    for (int i = 0; i < 10; i++) begin
      v = rd(SPR_EVEC, 32'h100); v.en_ = 0; v.gwe_ = 0; v.op = CTRL_ERET;
      v.saddr = SPR_EVEC; v.swe_ = 0; v.sdata = 32'h999; v.e_halt = 1;
      apply(v, 100 + i);
    end
    v = rd(SPR_EPC, 32'h50); v.irq = 1; v.e_halt = 1; v.e_fl = 1; v.e_npc = 30'h100; apply(v, 110);
    apply(rd(SPR_EPC, 32'h50), 111);
    apply(rd(SPR_CAUSE, 1), 112);
    apply(rd(SPR_STATUS, 2), 113);

    // HALT with ie=0: irq is ignored until reset
    v = idle(0); v.en_ = 0; v.op = CTRL_HALT; v.pc = 30'h60; v.e_fl = 1; v.e_npc = 30'h60; apply(v, 200);
    for (int i = 0; i < 5; i++) begin
      v = idle(0); v.irq = 1; v.e_halt = 1; apply(v, 201 + i);
    end
    v = idle(0); v.rst = 1; v.irq = 1; apply(v, 206);
    apply(rd(SPR_EPC, 0), 207);

    // SSR to STATUS racing a TRAP, with the exception held off by a stall
    apply(ssr(SPR_EVEC, 32'h200), 300);
    apply(ssr(SPR_STATUS, 1), 301);
    t = rd(SPR_EPC, 0); t.en_ = 0; t.pc = 30'h70; t.exp = EXP_TRAP; t.op = CTRL_SSR;
    t.saddr = SPR_STATUS; t.swe_ = 0; t.sdata = 3; t.gwe_ = 0;
    for (int i = 0; i < 3; i++) begin
      v = t; v.stall = 1; apply(v, 302 + i);
    end
    v = t; v.e_fl = 1; v.e_npc = 30'h200; apply(v, 305);
    apply(rd(SPR_EPC, 32'h70), 306);
    apply(rd(SPR_CAUSE, 3), 307);
    apply(rd(SPR_STATUS, 2), 308);

    // Randomized run against the reference model
    m_known = 0; m_mode = 0;
    m_ie = 0; m_pie = 0; m_epc = '0; m_evec = '0; m_cause = '0;
    for (int c = 0; c < 3000; c++) begin
      rst          = (c == 0) || ($urandom_range(0, 199) == 0);
      stall        = ($urandom_range(0, 9) == 0);
      mem_en_      = ($urandom_range(0, 9) < 3);
      mem_pc       = 30'($urandom);
      mem_w_addr   = 5'($urandom);
      mem_gpr_we_  = 1'($urandom_range(0, 1));
      mem_out      = $urandom;
      mem_exp_code = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 6)) : EXP_NONE;
      mem_ctrl_op  = 2'($urandom_range(0, 3));
      spr_w_addr   = 5'($urandom_range(0, 5));
      spr_we_      = ($urandom_range(0, 3) != 0);
      spr_w_data   = $urandom;
      irq          = ($urandom_range(0, 4) == 0);
      spr_r_addr   = 5'($urandom_range(0, 5));
      model_eval();
      @(negedge clk);
      chk(1000 + c, "rnd gpr_we_", 32'(gpr_we_), 32'(ex_we_));
      chk(1000 + c, "rnd flush", 32'(flush), 32'(ex_fl));
      chk(1000 + c, "rnd new_pc", 32'(new_pc), 32'(ex_npc));
      chk(1000 + c, "rnd halted", 32'(halted), 32'(ex_halt));
      if (m_known) chk(1000 + c, "rnd spr_r_data", spr_r_data, ex_rd);
      @(posedge clk); #1;
      model_commit();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
